// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size/state encodings and byte-lane order for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Byte offset 0 lives in bits [31:24].
  localparam bit LSU_BIG_ENDIAN = 1'b1;

  function automatic logic access_misaligned(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/halfword lane extract, sign/zero extend and store-lane merge
import lsu_pkg::*;

module lsu_align (
  input  lsu_size_e   size,
  input  logic        is_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    byte_lane  = LSU_BIG_ENDIAN ? (2'd3 - offset) : offset;
    half_lane  = LSU_BIG_ENDIAN ? ~offset[1] : offset[1];
    shamt      = (size == SZ_HALF) ? {half_lane, 4'b0000} : {byte_lane, 3'b000};
    lane_mask  = ((size == SZ_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    lane8      = 8'(mem_word >> shamt);
    lane16     = 16'(mem_word >> shamt);
    load_data  = mem_word;
    merge_data = store_data;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{is_signed & lane8[7]}}, lane8};
        merge_data = (mem_word & ~lane_mask) | ((store_data << shamt) & lane_mask);
      end
      SZ_HALF: begin
        load_data  = {{16{is_signed & lane16[15]}}, lane16};
        merge_data = (mem_word & ~lane_mask) | ((store_data << shamt) & lane_mask);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store unit over a word memory; LSU_BOUNDS_CHECK_EN rejects out-of-range addresses
import lsu_pkg::*;

module load_store_unit #(
  parameter int MEM_WORDS = 256,
  parameter int MEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  lsu_size_e   size_q;
  logic        we_q, signed_q, err_q;
  logic [31:0] addr_q, wdata_q, rword_q;
  logic        req_err, out_of_range;
  logic [31:0] load_data, merge_data;
  lsu_size_e   req_size_e;

  assign req_size_e   = lsu_size_e'(req_size);
  assign out_of_range = (|req_addr[31:MEM_AW+2]) ||
                        ({1'b0, req_addr[MEM_AW+1:2]} >= (MEM_AW+1)'(MEM_WORDS));

`ifdef LSU_BOUNDS_CHECK_EN
  assign req_err = access_misaligned(req_size_e, req_addr[1:0]) | out_of_range;
`else
  // Out-of-range addresses alias onto the decoded word index.
  logic unused_out_of_range;
  assign unused_out_of_range = out_of_range;
  assign req_err = access_misaligned(req_size_e, req_addr[1:0]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      size_q   <= SZ_BYTE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rword_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        size_q   <= req_size_e;
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= req_err;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == RD) rword_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_err)                              state_d = RESP;
        else if (req_we && req_size_e == SZ_WORD) state_d = WR;
        else                                      state_d = RD;
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_align u_align (
    .size       (size_q),
    .is_signed  (signed_q),
    .offset     (addr_q[1:0]),
    .mem_word   (rword_q),
    .store_data (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : 32'h0;
  // A reset arriving during WR must kill the write on that same edge.
  assign mem_we     = (state_q == WR) & ~rst;
  assign mem_addr   = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
  assign mem_wdata  = merge_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;
  logic [7:0]  rb [1024];
  int          n_checks, n_pass;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  wire unused_tb = &{1'b0, mem_addr[31:10], mem_addr[1:0]};

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]};
  endfunction

  // Memory is a flat array of bytes; the lowest address is the most significant byte.
  function automatic void model_access(input logic we, input logic [1:0] size, input logic sgn,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic err, output int lat, output logic [31:0] rdata);
    int b;
    b = int'(addr % 1024);
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0) ||
          (BOUNDS && addr >= 1024);
    rdata = 0;
    if (err) lat = 1;
    else if (!we) begin
      lat = 2;
      if (size == 2'd0) rdata = (sgn && rb[b] >= 8'h80) ? 32'hFFFF_FF00 | rb[b] : 32'(rb[b]);
      else if (size == 2'd1) rdata = (sgn && rb[b] >= 8'h80) ? {16'hFFFF, rb[b], rb[b+1]} : {16'h0, rb[b], rb[b+1]};
      else rdata = {rb[b], rb[b+1], rb[b+2], rb[b+3]};
    end else begin
      lat = (size == 2'd2) ? 2 : 3;
      if (size == 2'd0) rb[b] = wdata[7:0];
      else if (size == 2'd1) begin rb[b] = wdata[15:8]; rb[b+1] = wdata[7:0]; end
      else begin rb[b] = wdata[31:24]; rb[b+1] = wdata[23:16]; rb[b+2] = wdata[15:8]; rb[b+3] = wdata[7:0]; end
    end
  endfunction

  task automatic poke(input int w, input logic [31:0] v);
    pre_we = 1'b1; pre_idx = w[7:0]; pre_val = v;
    @(negedge clk);
    pre_we = 1'b0;
    rb[4*w] = v[31:24]; rb[4*w+1] = v[23:16]; rb[4*w+2] = v[15:8]; rb[4*w+3] = v[7:0];
  endtask

  // Drives one access from a negedge in IDLE and observes it; busy cycles carry junk requests.
  task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic err, output logic [31:0] rdata,
                            output int we_cnt, output logic [31:0] addr_seen,
                            output logic after_valid, output logic after_ready);
    lat = 0; err = 1'b0; rdata = 32'h0; we_cnt = 0; addr_seen = 32'h0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) addr_seen = mem_addr;
      if (mem_we) we_cnt++;
      if (resp_valid) begin
        lat = c; err = resp_err; rdata = resp_rdata;
        break;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    after_valid = resp_valid;
    after_ready = req_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", resp_err); else n_pass++;
    n_checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
    rst = 1'b0;
    for (int w = 0; w < 256; w++) poke(w, $urandom);
  endtask

  task automatic test_directed;
    int lat, wc, ml; logic err, me, av, ar; logic [31:0] rd, as, mr;
    model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, me, ml, mr);
    run_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd, wc, as, av, ar);
    n_checks++; if (lat !== 2) $display("FAIL wstore_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (wc !== 1) $display("FAIL wstore_we_cycles: got %0d want 1", wc); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL wstore_mem: got %h want deadbeef", mem[4]); else n_pass++;
    model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, me, ml, mr);
    run_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd, wc, as, av, ar);
    n_checks++; if (lat !== 2) $display("FAIL wload_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL wload_rdata: got %h want deadbeef", rd); else n_pass++;

    poke(4, 32'h11223344);
    model_access(1'b1, 2'd0, 1'b0, 32'h11, 32'hAA, me, ml, mr);
    run_access(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, lat, err, rd, wc, as, av, ar);
    n_checks++; if (lat !== 3) $display("FAIL bstore_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (mem[4] !== 32'h11AA3344) $display("FAIL bstore_merge: got %h want 11aa3344", mem[4]); else n_pass++;

    poke(4, 32'h80FF7F01);
    run_access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, err, rd, wc, as, av, ar);
    n_checks++; if (rd !== 32'h00000001) $display("FAIL sbyte_load: got %h want 00000001", rd); else n_pass++;
    run_access(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, lat, err, rd, wc, as, av, ar);
    n_checks++; if (rd !== 32'hFFFF80FF) $display("FAIL shalf_load: got %h want ffff80ff", rd); else n_pass++;
    run_access(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, lat, err, rd, wc, as, av, ar);
    n_checks++; if (rd !== 32'h000000FF) $display("FAIL ubyte_load: got %h want 000000ff", rd); else n_pass++;

    run_access(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, lat, err, rd, wc, as, av, ar);
    n_checks++; if (err !== 1'b1) $display("FAIL misalign_err: got %b want 1", err); else n_pass++;
    n_checks++; if (lat !== 1) $display("FAIL misalign_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (wc !== 0) $display("FAIL misalign_we: got %0d want 0", wc); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL misalign_rdata: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_reset_during_write;
    logic saw;
    poke(16, 32'h5555AAAA);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL abort_in_wr: got %b want 1", mem_we); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL abort_we_gate: got %b want 0", mem_we); else n_pass++;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", req_ready); else n_pass++;
    rst = 1'b0;
    saw = resp_valid;
    repeat (4) begin @(negedge clk); saw |= resp_valid; end
    n_checks++; if (saw !== 1'b0) $display("FAIL abort_no_resp: got %b want 0", saw); else n_pass++;
    n_checks++; if (mem[16] !== 32'h5555AAAA) $display("FAIL abort_mem: got %h want 5555aaaa", mem[16]); else n_pass++;
  endtask

  task automatic test_bounds;
    int lat, wc, ml; logic err, me, av, ar; logic [31:0] rd, as, mr;
    poke(0, 32'h01020304);
    model_access(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, me, ml, mr);
    run_access(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, lat, err, rd, wc, as, av, ar);
`ifdef LSU_BOUNDS_CHECK_EN
    n_checks++; if (err !== 1'b1) $display("FAIL bounds_err: got %b want 1", err); else n_pass++;
    n_checks++; if (mem[0] !== 32'h01020304) $display("FAIL bounds_mem: got %h want 01020304", mem[0]); else n_pass++;
`else
    n_checks++; if (err !== 1'b0) $display("FAIL alias_err: got %b want 0", err); else n_pass++;
    n_checks++; if (mem[0] !== 32'hCAFEF00D) $display("FAIL alias_mem: got %h want cafef00d", mem[0]); else n_pass++;
`endif
  endtask

  task automatic test_random;
    int lat, wc, el, w; logic err, ee, av, ar, we, sgn; logic [1:0] sz; logic [31:0] rd, as, er, a, wd;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom); sz = 2'($urandom_range(0, 3)); sgn = 1'($urandom);
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 7)) << 10);
      wd = $urandom;
      w = int'(a[9:2]);
      model_access(we, sz, sgn, a, wd, ee, el, er);
      run_access(we, sz, sgn, a, wd, lat, err, rd, wc, as, av, ar);
      n_checks++; if (lat !== el) $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, el); else n_pass++;
      n_checks++; if (err !== ee) $display("FAIL rnd_err[%0d]: got %b want %b", i, err, ee); else n_pass++;
      n_checks++; if (rd !== er) $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rd, er); else n_pass++;
      n_checks++; if (wc !== ((we && !ee) ? 1 : 0)) $display("FAIL rnd_we_cycles[%0d]: got %0d want %0d", i, wc, (we && !ee) ? 1 : 0); else n_pass++;
      n_checks++; if (as !== {a[31:2], 2'b00}) $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, as, {a[31:2], 2'b00}); else n_pass++;
      n_checks++; if (av !== 1'b0 || ar !== 1'b1) $display("FAIL rnd_single_pulse[%0d]: got valid=%b ready=%b want 0/1", i, av, ar); else n_pass++;
      n_checks++; if (mem[w] !== ref_word(w)) $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem[w], ref_word(w)); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    test_reset;
    test_directed;
    test_reset_during_write;
    test_bounds;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning the number of 32-bit words in the downstream data memory.
REQ-002 SHALL have parameter MEM_AW, default 8, meaning the word-index width, equal to log2(MEM_WORDS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the CPU presents an access.
REQ-006 SHALL have port req_ready, output, 1 bit: the unit can accept an access.
REQ-007 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_size, input, 2 bits: 0 byte, 1 halfword, 2 word; 3 is reserved and treated as an error.
REQ-009 SHALL have port req_signed, input, 1 bit: sign-extend sub-word loads.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, 32 bits: load result, extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: access rejected; qualified by resp_valid.
REQ-015 SHALL have ports mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32) and mem_rdata (input, 32): the word-memory side, which has a combinational read and a write on the clock edge.

Function
REQ-016 SHALL implement FSM states IDLE, RD, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL, in IDLE on req_valid, capture all req_* signals into registers.
- A misaligned or reserved-size access (halfword with addr[0]=1; word with addr[1:0]≠0; size 3) SHALL go to RESP with the error flag set.
- A load or a sub-word store SHALL go to RD.
- A word store SHALL go to WR.
REQ-018 SHALL drive mem_addr as {captured addr[31:2], 2'b00} in every non-IDLE state, and 0 in IDLE.
REQ-019 SHALL, in RD, register mem_rdata.
- Load: SHALL then go to RESP.
- Store: SHALL then go to WR.
REQ-020 SHALL assert mem_we in WR only, for exactly one cycle.
- Byte/halfword store: mem_wdata SHALL be the registered read word with only the addressed lanes replaced.
- Word store: mem_wdata SHALL be req_wdata.
REQ-021 SHALL use big-endian byte lanes: offset 0 maps to bits [31:24] and offset 3 to bits [7:0]; halfword offset 0 maps to [31:16].
REQ-022 SHALL extract the addressed lanes for loads and zero- or sign-extend them per req_signed; req_signed SHALL be ignored for word loads.
REQ-023 SHALL assert resp_valid for exactly one cycle in RESP and then return to IDLE; there is no response back-pressure.
REQ-024 SHALL meet these latencies from the accepting edge, counted as the cycle number in which resp_valid is high:
- Error: cycle 1.
- Load: cycle 2.
- Word store: cycle 2.
- Sub-word store: cycle 3.
REQ-025 SHALL NOT assert mem_we for an errored access.
REQ-026 SHALL ignore req_valid while not in IDLE; the CPU SHALL hold the request until req_ready.

Reset
REQ-027 SHALL, on rst high at a clock edge, enter IDLE and clear all captured registers, resp_valid, resp_err and resp_rdata.
REQ-028 SHALL gate mem_we with ~rst, so that reset asserted during WR suppresses the write in that cycle.
REQ-029 SHALL return to IDLE on reset mid-operation with no response emitted for the aborted access.

Configuration
REQ-030 SHALL, when LSU_BOUNDS_CHECK_EN is defined, flag any access with addr ≥ MEM_WORDS*4 as an error under REQ-017, with no memory access.
REQ-031 SHALL, when LSU_BOUNDS_CHECK_EN is undefined, pass out-of-range addresses through unchanged; they alias because memory decodes addr[MEM_AW+1:2].

Structure
REQ-032 SHALL place the size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), the FSM state encodings and the endianness constant in shared package lsu_pkg.
REQ-033 SHALL implement lane extract/merge/extend in combinational sub-module lsu_align, instantiated once.

Verification
REQ-034 Word store addr 0x10, data 0xDEADBEEF -> mem_we for one cycle, with resp_valid in cycle 2; a following word load from 0x10 -> resp_rdata 0xDEADBEEF in cycle 2.
REQ-035 Byte store addr 0x11, data 0x000000AA over a word of 0x11223344 -> word becomes 0x11AA3344, with resp_valid in cycle 3.
REQ-036 Over a word of 0x80FF7F01 -> signed byte load addr 0x13 returns 0x00000001; signed halfword load addr 0x10 returns 0xFFFF80FF; unsigned byte load addr 0x11 returns 0x000000FF.
REQ-037 Halfword load addr 0x21 -> resp_err=1 in cycle 1, mem_we never asserted, resp_rdata 0.
REQ-038 rst asserted during WR of a store to 0x40 -> memory word unchanged, no resp_valid, req_ready=1 on the next cycle.
REQ-039 With LSU_BOUNDS_CHECK_EN, word store to 0x400 -> resp_err=1 and word 0 unchanged; without it -> word 0 is written.
